// File: rtl/lstm_pkg.sv
// ---------------------------------------------------------------------------
// lstm_pkg
// Shared definitions for the LSTM cell-state storage blocks.
//   state_t      : sequencer state of the cell-state buffer
//   lstm_clog2   : ceil(log2(n)) clamped to at least 1 bit
//   lstm_depth   : number of stored words, NUM_LSTM*(TIMESTEP+1)
//   lstm_addr_w  : address width needed to cover lstm_depth
// ---------------------------------------------------------------------------
package lstm_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_FWD   = 2'd2,
        S_BWD   = 2'd3
    } state_t;

    // A zero-width vector is illegal, so degenerate sizes still get one bit.
    function automatic int lstm_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int lstm_depth(input int numLstm, input int timestep);
        return numLstm * (timestep + 1);
    endfunction

    function automatic int lstm_addr_w(input int numLstm, input int timestep);
        return lstm_clog2(lstm_depth(numLstm, timestep));
    endfunction

endpackage

// File: rtl/cstate_ram.sv
// ---------------------------------------------------------------------------
// cstate_ram
// Simple dual-port synchronous RAM (one write port, one read port) with a
// registered read, written so that synthesis maps it onto block RAM.
//   clk      : clock
//   rst      : synchronous active-high reset of the read register only
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_re     : read enable; the read register holds when low
//   i_raddr  : read address
//   o_rdata  : registered read data, valid one cycle after i_re
// ---------------------------------------------------------------------------
module cstate_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 424,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage array: no reset, so contents survive rst and the array stays
    // a pure memory for the block-RAM mapper.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Output register: the reset maps onto the block-RAM output latch reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cell_state_buffer.sv
// ---------------------------------------------------------------------------
// cell_state_buffer
// LSTM cell-state store for BPTT. Holds c[0..TIMESTEP] for NUM_LSTM units.
// The forward pass writes c[1..TIMESTEP] in order; the backward pass reads
// in reverse time and returns c[t] and c[t-1] of the same unit together.
//   clk        : clock
//   rst        : synchronous active-high reset (memory contents retained)
//   clr        : zero-fill whole store (accepted in IDLE only)
//   start_fwd  : begin forward write sequence (IDLE only)
//   start_bwd  : begin backward read sequence (IDLE only)
//   wr_en      : write wr_data at the forward pointer (FWD only)
//   wr_data    : signed c[t] value to store
//   rd_en      : read at the backward pointer (BWD only)
//   o_cur      : c[t]   of the read, one cycle after rd_en
//   o_prev     : c[t-1] of the read, one cycle after rd_en
//   o_valid    : o_cur/o_prev updated this cycle
//   busy       : sequencer not in IDLE
//   fwd_done   : pulse the cycle after the final forward write
//   bwd_done   : pulse together with the final backward o_valid
// ---------------------------------------------------------------------------
module cell_state_buffer import lstm_pkg::*; #(
    parameter int WIDTH    = 32,
    parameter int NUM_LSTM = 53,
    parameter int TIMESTEP = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    start_fwd,
    input  logic                    start_bwd,
    input  logic                    wr_en,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic                    rd_en,
    output logic signed [WIDTH-1:0] o_cur,
    output logic signed [WIDTH-1:0] o_prev,
    output logic                    o_valid,
    output logic                    busy,
    output logic                    fwd_done,
    output logic                    bwd_done
);

    localparam int DEPTH = lstm_depth(NUM_LSTM, TIMESTEP);
    localparam int AW    = lstm_addr_w(NUM_LSTM, TIMESTEP);
    localparam int TW    = lstm_clog2(TIMESTEP + 1);
    localparam int UW    = lstm_clog2(NUM_LSTM);

    localparam logic [AW-1:0] A_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] A_N     = AW'(NUM_LSTM);
    localparam logic [AW-1:0] A_BACK  = AW'(2 * NUM_LSTM - 1);
    localparam logic [AW-1:0] A_BSTRT = AW'(TIMESTEP * NUM_LSTM);
    localparam logic [AW-1:0] A_ONE   = AW'(1);
    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMESTEP);
    localparam logic [UW-1:0] U_ONE   = UW'(1);
    localparam logic [UW-1:0] U_LAST  = UW'(NUM_LSTM - 1);

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_t;
    logic [UW-1:0]   r_u;
    logic [AW-1:0]   r_addr;
    logic            r_valid;
    logic            r_fwd_done;
    logic            r_bwd_done;

    logic            w_fwd_last;
    logic            w_bwd_last;
    logic            w_clr_last;
    logic            w_we;
    logic [WIDTH-1:0] w_wdata;
    logic            w_re;
    logic            w_busy;
    logic [AW-1:0]   w_prev_addr;

    // Last-element detection for each sequence, qualified by its strobe.
    assign w_fwd_last  = wr_en && (r_t == T_LAST) && (r_u == U_LAST);
    assign w_bwd_last  = rd_en && (r_t == T_ONE)  && (r_u == U_LAST);
    assign w_clr_last  = (r_addr == A_LAST);

    // c[t-1][u] sits exactly one timestep (NUM_LSTM words) below c[t][u].
    assign w_prev_addr = r_addr - A_N;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; IDLE command priority is clr, then start_fwd, then
    // start_bwd, and every command is ignored once a sequence is running.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (clr)            w_next = S_CLEAR;
                else if (start_fwd) w_next = S_FWD;
                else if (start_bwd) w_next = S_BWD;
            end
            S_CLEAR: if (w_clr_last) w_next = S_IDLE;
            S_FWD:   if (w_fwd_last) w_next = S_IDLE;
            S_BWD:   if (w_bwd_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output/control decode. Writes are suppressed while rst is asserted so
    // an aborted sequence never lands a stray word during the reset cycle.
    always_comb begin
        w_busy  = (r_state != S_IDLE);
        w_we    = 1'b0;
        w_wdata = wr_data;
        w_re    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_we    = !rst;
                w_wdata = '0;
            end
            S_FWD:   w_we = !rst && wr_en;
            S_BWD:   w_re = rd_en;
            default: ;
        endcase
    end

    // Pointer datapath. r_addr tracks t*NUM_LSTM+u incrementally: +1 per
    // element, and on a backward timestep change it steps back 2*NUM_LSTM-1
    // to land on u=0 of the previous timestep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_t    <= '0;
            r_u    <= '0;
            r_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr) begin
                        r_addr <= '0;
                    end else if (start_fwd) begin
                        r_t    <= T_ONE;
                        r_u    <= '0;
                        r_addr <= A_N;
                    end else if (start_bwd) begin
                        r_t    <= T_LAST;
                        r_u    <= '0;
                        r_addr <= A_BSTRT;
                    end
                end
                S_CLEAR: begin
                    r_addr <= w_clr_last ? '0 : r_addr + A_ONE;
                end
                S_FWD: begin
                    if (wr_en) begin
                        if (w_fwd_last) begin
                            r_t    <= '0;
                            r_u    <= '0;
                            r_addr <= '0;
                        end else begin
                            r_addr <= r_addr + A_ONE;
                            if (r_u == U_LAST) begin
                                r_u <= '0;
                                r_t <= r_t + T_ONE;
                            end else begin
                                r_u <= r_u + U_ONE;
                            end
                        end
                    end
                end
                S_BWD: begin
                    if (rd_en) begin
                        if (w_bwd_last) begin
                            r_t    <= '0;
                            r_u    <= '0;
                            r_addr <= '0;
                        end else if (r_u == U_LAST) begin
                            r_u    <= '0;
                            r_t    <= r_t - T_ONE;
                            r_addr <= r_addr - A_BACK;
                        end else begin
                            r_u    <= r_u + U_ONE;
                            r_addr <= r_addr + A_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags aligned with the registered RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_fwd_done <= 1'b0;
            r_bwd_done <= 1'b0;
        end else begin
            r_valid    <= w_re;
            r_fwd_done <= (r_state == S_FWD) && w_fwd_last;
            r_bwd_done <= (r_state == S_BWD) && w_bwd_last;
        end
    end

    // Two identically written copies give c[t] and c[t-1] in one access.
    cstate_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram_cur (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (r_addr),
        .o_rdata (o_cur)
    );

    cstate_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram_prev (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_prev_addr),
        .o_rdata (o_prev)
    );

    assign o_valid  = r_valid;
    assign busy     = w_busy;
    assign fwd_done = r_fwd_done;
    assign bwd_done = r_bwd_done;

endmodule

// File: tb/tb_cell_state_buffer.sv
// ---------------------------------------------------------------------------
// tb_cell_state_buffer
// Directed bench for cell_state_buffer with NUM_LSTM=3, TIMESTEP=2,
// WIDTH=16 (depth 9). Inputs change 1 ns after a rising edge and outputs
// are sampled at that same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_cell_state_buffer;

    localparam int WIDTH    = 16;
    localparam int NUM_LSTM = 3;
    localparam int TIMESTEP = 2;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             startFwd;
    logic             startBwd;
    logic             wrEn;
    logic [WIDTH-1:0] wrData;
    logic             rdEn;
    logic [WIDTH-1:0] oCur;
    logic [WIDTH-1:0] oPrev;
    logic             oValid;
    logic             busy;
    logic             fwdDone;
    logic             bwdDone;

    int passCount  = 0;
    int totalCount = 0;

    // One table row: inputs for a cycle and the outputs expected after it.
    typedef struct {
        logic             clr;
        logic             startFwd;
        logic             startBwd;
        logic             wrEn;
        logic             rdEn;
        logic [WIDTH-1:0] wrData;
        logic             expBusy;
        logic             expValid;
        logic             expFwdDone;
        logic             expBwdDone;
        logic             chkData;
        logic [WIDTH-1:0] expCur;
        logic [WIDTH-1:0] expPrev;
    } vec_t;

    vec_t             vecs [15];
    logic [WIDTH-1:0] writeVals [6];
    logic [WIDTH-1:0] expCur [6];
    logic [WIDTH-1:0] expPrev [6];

    cell_state_buffer #(
        .WIDTH    (WIDTH),
        .NUM_LSTM (NUM_LSTM),
        .TIMESTEP (TIMESTEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .start_fwd (startFwd),
        .start_bwd (startBwd),
        .wr_en     (wrEn),
        .wr_data   (wrData),
        .rd_en     (rdEn),
        .o_cur     (oCur),
        .o_prev    (oPrev),
        .o_valid   (oValid),
        .busy      (busy),
        .fwd_done  (fwdDone),
        .bwd_done  (bwdDone)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every control input to its idle level.
    task automatic applyStimulus();
        clr      = 1'b0;
        startFwd = 1'b0;
        startBwd = 1'b0;
        wrEn     = 1'b0;
        rdEn     = 1'b0;
        wrData   = '0;
    endtask

    // Single comparison with pass/total bookkeeping.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(logic c, logic sf, logic sb, logic we,
                                   logic re, logic [WIDTH-1:0] d, logic eb,
                                   logic ev, logic efd, logic ebd, logic cd,
                                   logic [WIDTH-1:0] ec, logic [WIDTH-1:0] ep);
        vec_t v;
        v.clr = c; v.startFwd = sf; v.startBwd = sb; v.wrEn = we; v.rdEn = re;
        v.wrData = d; v.expBusy = eb; v.expValid = ev; v.expFwdDone = efd;
        v.expBwdDone = ebd; v.chkData = cd; v.expCur = ec; v.expPrev = ep;
        return v;
    endfunction

    task automatic setVals(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                           input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] a3,
                           input logic [WIDTH-1:0] a4, input logic [WIDTH-1:0] a5);
        writeVals[0] = a0; writeVals[1] = a1; writeVals[2] = a2;
        writeVals[3] = a3; writeVals[4] = a4; writeVals[5] = a5;
    endtask

    // Expected backward pairs given the memory image t1 = m1[], t2 = m2[]
    // and c[0] = 0: reads go t=2 then t=1, unit 0 first.
    task automatic setExp(input logic [WIDTH-1:0] m10, input logic [WIDTH-1:0] m11,
                          input logic [WIDTH-1:0] m12, input logic [WIDTH-1:0] m20,
                          input logic [WIDTH-1:0] m21, input logic [WIDTH-1:0] m22);
        expCur[0] = m20; expPrev[0] = m10;
        expCur[1] = m21; expPrev[1] = m11;
        expCur[2] = m22; expPrev[2] = m12;
        expCur[3] = m10; expPrev[3] = '0;
        expCur[4] = m11; expPrev[4] = '0;
        expCur[5] = m12; expPrev[5] = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus();
        tick();
        rst = 1'b0;
    endtask

    // Issue clr and count busy cycles, bounded so a stuck DUT still ends.
    task automatic doClear();
        int cnt;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            tick();
        end
        checkOutput("clear_busy_cycles", cnt, 9);
    endtask

    task automatic beginFwd();
        startFwd = 1'b1;
        tick();
        startFwd = 1'b0;
        checkOutput("fwd_start_busy", busy, 1);
    endtask

    // Write writeVals[lo..hi]; index 5 is the final element of the pass.
    task automatic writeRange(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            wrEn   = 1'b1;
            wrData = writeVals[i];
            tick();
            wrEn   = 1'b0;
            checkOutput($sformatf("fwd_done_w%0d", i), fwdDone, (i == 5) ? 1 : 0);
            checkOutput($sformatf("fwd_busy_w%0d", i), busy, (i == 5) ? 0 : 1);
        end
    endtask

    // Full backward pass with 'gap' idle cycles after each rd_en.
    task automatic runBwd(input string tag, input int gap);
        startBwd = 1'b1;
        tick();
        startBwd = 1'b0;
        checkOutput({tag, "_start_busy"}, busy, 1);
        checkOutput({tag, "_start_valid"}, oValid, 0);
        for (int i = 0; i < 6; i++) begin
            rdEn = 1'b1;
            tick();
            rdEn = 1'b0;
            checkOutput($sformatf("%s_valid_r%0d", tag, i), oValid, 1);
            checkOutput($sformatf("%s_cur_r%0d", tag, i), oCur, expCur[i]);
            checkOutput($sformatf("%s_prev_r%0d", tag, i), oPrev, expPrev[i]);
            checkOutput($sformatf("%s_bdone_r%0d", tag, i), bwdDone, (i == 5) ? 1 : 0);
            checkOutput($sformatf("%s_busy_r%0d", tag, i), busy, (i == 5) ? 0 : 1);
            for (int g = 0; g < gap; g++) begin
                tick();
                checkOutput($sformatf("%s_gapvalid_r%0d", tag, i), oValid, 0);
                checkOutput($sformatf("%s_gapcur_r%0d", tag, i), oCur, expCur[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus();
        repeat (2) tick();

        // Reset state.
        doReset();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", oValid, 0);
        checkOutput("rst_fwd_done", fwdDone, 0);
        checkOutput("rst_bwd_done", bwdDone, 0);
        checkOutput("rst_cur", oCur, 0);
        checkOutput("rst_prev", oPrev, 0);

        // Clear then read back all zeros.
        doClear();
        setExp('0, '0, '0, '0, '0, '0);
        runBwd("clrbwd", 0);

        // Table-driven forward then backward pass.
        doClear();
        vecs[0]  = mkVec(0,1,0,0,0,16'h0000, 1,0,0,0,0,16'h0000,16'h0000);
        vecs[1]  = mkVec(0,0,0,1,0,16'h0011, 1,0,0,0,0,16'h0000,16'h0000);
        vecs[2]  = mkVec(0,0,0,1,0,16'h0012, 1,0,0,0,0,16'h0000,16'h0000);
        vecs[3]  = mkVec(0,0,0,1,0,16'h0013, 1,0,0,0,0,16'h0000,16'h0000);
        vecs[4]  = mkVec(0,0,0,1,0,16'h0021, 1,0,0,0,0,16'h0000,16'h0000);
        vecs[5]  = mkVec(0,0,0,1,0,16'h0022, 1,0,0,0,0,16'h0000,16'h0000);
        vecs[6]  = mkVec(0,0,0,1,0,16'h0023, 0,0,1,0,0,16'h0000,16'h0000);
        vecs[7]  = mkVec(0,0,1,0,0,16'h0000, 1,0,0,0,0,16'h0000,16'h0000);
        vecs[8]  = mkVec(0,0,0,0,1,16'h0000, 1,1,0,0,1,16'h0021,16'h0011);
        vecs[9]  = mkVec(0,0,0,0,1,16'h0000, 1,1,0,0,1,16'h0022,16'h0012);
        vecs[10] = mkVec(0,0,0,0,1,16'h0000, 1,1,0,0,1,16'h0023,16'h0013);
        vecs[11] = mkVec(0,0,0,0,1,16'h0000, 1,1,0,0,1,16'h0011,16'h0000);
        vecs[12] = mkVec(0,0,0,0,1,16'h0000, 1,1,0,0,1,16'h0012,16'h0000);
        vecs[13] = mkVec(0,0,0,0,1,16'h0000, 0,1,0,1,1,16'h0013,16'h0000);
        vecs[14] = mkVec(0,0,0,0,0,16'h0000, 0,0,0,0,1,16'h0013,16'h0000);
        for (int i = 0; i < 15; i++) begin
            clr      = vecs[i].clr;
            startFwd = vecs[i].startFwd;
            startBwd = vecs[i].startBwd;
            wrEn     = vecs[i].wrEn;
            rdEn     = vecs[i].rdEn;
            wrData   = vecs[i].wrData;
            tick();
            checkOutput($sformatf("tbl_busy_%0d", i), busy, vecs[i].expBusy);
            checkOutput($sformatf("tbl_valid_%0d", i), oValid, vecs[i].expValid);
            checkOutput($sformatf("tbl_fdone_%0d", i), fwdDone, vecs[i].expFwdDone);
            checkOutput($sformatf("tbl_bdone_%0d", i), bwdDone, vecs[i].expBwdDone);
            if (vecs[i].chkData) begin
                checkOutput($sformatf("tbl_cur_%0d", i), oCur, vecs[i].expCur);
                checkOutput($sformatf("tbl_prev_%0d", i), oPrev, vecs[i].expPrev);
            end
        end
        applyStimulus();

        // Negative and extreme values, stored bit-exact.
        setVals(16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001);
        beginFwd();
        writeRange(0, 5);
        setExp(16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001);
        runBwd("neg", 0);

        // Same data read with rd_en every third cycle.
        runBwd("gap", 2);

        // Commands and rd_en during FWD must be ignored.
        setVals(16'h0A01, 16'h0A02, 16'h0A03, 16'h0B01, 16'h0B02, 16'h0B03);
        beginFwd();
        writeRange(0, 1);
        startBwd = 1'b1;
        clr      = 1'b1;
        rdEn     = 1'b1;
        tick();
        applyStimulus();
        checkOutput("ign_busy", busy, 1);
        checkOutput("ign_valid", oValid, 0);
        tick();
        checkOutput("ign_valid2", oValid, 0);
        writeRange(2, 5);
        setExp(16'h0A01, 16'h0A02, 16'h0A03, 16'h0B01, 16'h0B02, 16'h0B03);
        runBwd("ign", 0);

        // Reset after four forward writes: partial entries retained.
        setVals(16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04, 16'h0000, 16'h0000);
        beginFwd();
        writeRange(0, 3);
        doReset();
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_valid", oValid, 0);
        checkOutput("midrst_fdone", fwdDone, 0);
        checkOutput("midrst_cur", oCur, 0);
        checkOutput("midrst_prev", oPrev, 0);
        setExp(16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04, 16'h0B02, 16'h0B03);
        runBwd("midrst", 0);

        // Next FWD restarts at t=1,u=0 and only overwrites what it writes.
        setVals(16'h0D01, 16'h0D02, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        beginFwd();
        writeRange(0, 1);
        doReset();
        setExp(16'h0D01, 16'h0D02, 16'h0C03, 16'h0C04, 16'h0B02, 16'h0B03);
        runBwd("restart", 0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/cell_state_buffer.md
# cell_state_buffer

Parametrised LSTM cell-state store for BPTT training. It holds c[t] for NUM_LSTM units over TIMESTEP+1 steps, with c[0] as the initial state. The forward pass writes in sequence through internal address counters. The backward pass reads in reverse-time order and returns c[t] and c[t-1] together each cycle, so the gradient datapath gets both operands in one access. Sits between the LSTM cell array and the backprop delta unit; supersedes the single-port, externally addressed cell-state memory.

## Interface
- WIDTH, 32, signed cell-state word width
- NUM_LSTM, 53, LSTM units per timestep
- TIMESTEP, 7, timesteps stored after c[0]; depth = NUM_LSTM*(TIMESTEP+1)
- clk  in  1  clock; one clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  start zero-fill of whole store (IDLE only)
- start_fwd  in  1  begin forward write sequence (IDLE only)
- start_bwd  in  1  begin backward read sequence (IDLE only)
- wr_en  in  1  write wr_data at current forward pointer (FWD only)
- wr_data  in  WIDTH  signed c[t] value
- rd_en  in  1  read at current backward pointer (BWD only)
- o_cur  out  WIDTH  signed c[t]
- o_prev  out  WIDTH  signed c[t-1]
- o_valid  out  1  o_cur/o_prev valid this cycle
- busy  out  1  state != IDLE
- fwd_done  out  1  one-cycle pulse after last forward write
- bwd_done  out  1  one-cycle pulse with last backward o_valid

## Operation
- States: IDLE, CLEAR, FWD, BWD.
- IDLE priority: clr > start_fwd > start_bwd. Commands outside IDLE are ignored. wr_en is ignored outside FWD; rd_en is ignored outside BWD.
- Address = t*NUM_LSTM + u. Keep it in an incremental counter with no multiplier. Prev address = addr − NUM_LSTM.
- CLEAR: write 0 to addresses 0..depth−1, one per cycle. Then go to IDLE. No done pulse.
- FWD: pointer starts at t=1, u=0. Each wr_en writes, then increments u. When u=NUM_LSTM−1, u wraps to 0 and t increments. The write at t=TIMESTEP, u=NUM_LSTM−1 returns the FSM to IDLE and pulses fwd_done. c[0] is never written by FWD; it stays at its CLEAR value of 0.
- BWD: pointer starts at t=TIMESTEP, u=0. Each rd_en reads c[t][u] into o_cur and c[t−1][u] into o_prev, then increments u. When u=NUM_LSTM−1, u wraps to 0 and t decrements. The read at t=1, u=NUM_LSTM−1 returns the FSM to IDLE. Its data is still returned with o_valid, and bwd_done is high in that same cycle.
- Gaps are allowed: wr_en/rd_en may idle any number of cycles within FWD/BWD.
- Arithmetic: none on data. Values are stored bit-exact, signed WIDTH.
- Reset: state IDLE; pointers t=0, u=0; o_cur=0, o_prev=0, o_valid=0, busy=0, fwd_done=0, bwd_done=0.
  - Memory contents are retained; use clr to zero them.
  - Reset mid-sequence aborts the sequence. IDLE applies from the next cycle, and partial writes are kept.

## Timing
- Write: wr_en at cycle n; the data is readable by a rd_en at cycle n+1 or later.
- Read latency 1: rd_en at cycle n gives o_cur, o_prev and o_valid at n+1. Outputs hold their last value when o_valid=0.
- CLEAR takes exactly depth cycles. busy rises in the cycle after clr and falls after the last zero write.
- fwd_done is high in the cycle after the final wr_en; busy=0 in that same cycle.
- start_* asserted on the cycle busy falls is accepted.

## Structure
- Shared package lstm_pkg: the state enum (IDLE/CLEAR/FWD/BWD), a depth constant function, and an address-width function clog2(NUM_LSTM*(TIMESTEP+1)).
- Sub-module cstate_ram: 1-write/1-read synchronous RAM with WIDTH×depth and a registered read.
  - Instantiate two copies, each written identically: one read at addr, one at prev addr.
  - Inference target: block RAM.

## Test plan
Bench parameters: NUM_LSTM=3, TIMESTEP=2, WIDTH=16, depth=9.
- Clear: rst, then clr → busy high for 9 cycles. After that, a full BWD gives o_cur=o_prev=0 for all 6 reads.
- Forward/backward: clr; FWD writes 0x0011,0x0012,0x0013 (t=1) then 0x0021,0x0022,0x0023 (t=2); fwd_done follows the 6th write. BWD then returns these (o_cur,o_prev) pairs, with bwd_done on the 6th valid:
  - (0x0021,0x0011), (0x0022,0x0012), (0x0023,0x0013)
  - (0x0011,0), (0x0012,0), (0x0013,0)
- Negative values: write −1 (0xFFFF) and −32768 (0x8000) → read back bit-exact, sign preserved.
- Ignored commands: start_bwd and clr during FWD, and rd_en during FWD → no state change, o_valid stays 0, and the write sequence completes normally.
- Gapped handshake: rd_en asserted every third cycle → o_valid only one cycle after each rd_en, order unchanged.
- Reset mid-FWD after 4 writes: outputs go to their reset values. The next FWD restarts at t=1, u=0, and the 4 earlier entries remain until overwritten.
